eval_arbiter: RTL and testbench

EVAL_ARBITER -- requirements
Module: eval_arbiter

---
 rtl/eval_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_eval_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/eval_arbiter.sv
// Three-lane round-robin expression evaluator: grants one lane, evaluates {a,op,b}, strobes the result.
// Optional 4-cycle restoring divider for op 4'hD is built only when EVAL_DIV_EN is defined.
module eval_arbiter #(
  parameter logic [7:0] ERR_CODE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [35:0] exp_bus,
  input  logic        flush,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic        res_valid,
  output logic [1:0]  res_lane,
  output logic [7:0]  res_ans,
  output logic        res_err
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  a_q, a_d, op_q, op_d, b_q, b_d;
  logic        resValid_q, resValid_d;
  logic [1:0]  resLane_q, resLane_d;
  logic [7:0]  resAns_q, resAns_d;
  logic        resErr_q, resErr_d;

  logic [1:0]  l1, l2, l3, win;
  logic [11:0] expSel;
  logic [7:0]  singleAns;
  logic        singleErr;

`ifdef EVAL_DIV_EN
  logic [3:0]  rem_q, rem_d, quo_q, quo_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  remShift;
  logic [3:0]  remNext, quoNext;
`endif

  function automatic logic [1:0] nextLane(input logic [1:0] l);
    case (l)
      2'd0:    nextLane = 2'd1;
      2'd1:    nextLane = 2'd2;
      default: nextLane = 2'd0;
    endcase
  endfunction

  // Search order starts at the lane after the last grant.
  always_comb begin
    l1 = nextLane(ptr_q);
    l2 = nextLane(l1);
    l3 = nextLane(l2);
    if (req[l1])      win = l1;
    else if (req[l2]) win = l2;
    else              win = l3;
    case (win)
      2'd1:    expSel = exp_bus[23:12];
      2'd2:    expSel = exp_bus[35:24];
      default: expSel = exp_bus[11:0];
    endcase
  end

  always_comb begin
    singleAns = 8'h00;
    singleErr = 1'b0;
    case (op_q)
      4'hA:    singleAns = {4'h0, a_q} + {4'h0, b_q};
      4'hB:    singleAns = {4'h0, a_q} - {4'h0, b_q};
      4'hC:    singleAns = {4'h0, a_q} * {4'h0, b_q};
      default: singleErr = 1'b1;
    endcase
    if ({a_q, op_q, b_q} == 12'h000) singleErr = 1'b1;
    if (singleErr) singleAns = ERR_CODE;
  end

`ifdef EVAL_DIV_EN
  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    remShift = {rem_q, quo_q[3]};
    if (remShift >= {1'b0, b_q}) begin
      remNext = remShift[3:0] - b_q;
      quoNext = {quo_q[2:0], 1'b1};
    end else begin
      remNext = remShift[3:0];
      quoNext = {quo_q[2:0], 1'b0};
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = 3'b000;
    lane_d     = lane_q;
    a_d        = a_q;
    op_d       = op_q;
    b_d        = b_q;
    resValid_d = 1'b0;
    resLane_d  = resLane_q;
    resAns_d   = resAns_q;
    resErr_d   = resErr_q;
`ifdef EVAL_DIV_EN
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
`endif
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_d           = EXEC;
            gnt_d             = 3'b001 << win;
            ptr_d             = win;
            lane_d            = win;
            {a_d, op_d, b_d}  = expSel;
`ifdef EVAL_DIV_EN
            rem_d             = 4'h0;
            quo_d             = expSel[11:8];
            cnt_d             = 2'd0;
`endif
          end
        end
        EXEC: begin
`ifdef EVAL_DIV_EN
          if (op_q == 4'hD && b_q != 4'h0) begin
            rem_d = remNext;
            quo_d = quoNext;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_d    = DONE;
              resValid_d = 1'b1;
              resLane_d  = lane_q;
              resAns_d   = {4'h0, quoNext};
              resErr_d   = 1'b0;
            end
          end else
`endif
          begin
            state_d    = DONE;
            resValid_d = 1'b1;
            resLane_d  = lane_q;
            resAns_d   = singleAns;
            resErr_d   = singleErr;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd2;
      gnt_q      <= 3'b000;
      lane_q     <= 2'd0;
      a_q        <= 4'h0;
      op_q       <= 4'h0;
      b_q        <= 4'h0;
      resValid_q <= 1'b0;
      resLane_q  <= 2'd0;
      resAns_q   <= 8'h00;
      resErr_q   <= 1'b0;
`ifdef EVAL_DIV_EN
      rem_q      <= 4'h0;
      quo_q      <= 4'h0;
      cnt_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      lane_q     <= lane_d;
      a_q        <= a_d;
      op_q       <= op_d;
      b_q        <= b_d;
      resValid_q <= resValid_d;
      resLane_q  <= resLane_d;
      resAns_q   <= resAns_d;
      resErr_q   <= resErr_d;
`ifdef EVAL_DIV_EN
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = resValid_q;
  assign res_lane  = resLane_q;
  assign res_ans   = resAns_q;
  assign res_err   = resErr_q;

endmodule

// File: tb/tb_eval_arbiter.sv
// Directed bench for eval_arbiter: hand-computed results, grant order, latency, flush and reset cases.
// Expectations for op 4'hD follow EVAL_DIV_EN the same way the design does.
module tb_eval_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [35:0] exp_bus;
  logic        flush;
  logic [2:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic [1:0]  res_lane;
  logic [7:0]  res_ans;
  logic        res_err;

  int checkCount = 0;
  int errorCount = 0;

  eval_arbiter #(.ERR_CODE(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .exp_bus   (exp_bus),
    .flush     (flush),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_lane  (res_lane),
    .res_ans   (res_ans),
    .res_err   (res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] mask, input logic [11:0] expr);
    @(negedge clk);
    exp_bus = {3{expr}};
    req     = mask;
  endtask

  // Waits (bounded) for a grant and checks which lane won.
  task automatic waitGrant(input string tag, input logic [2:0] expGnt);
    int n = 0;
    @(negedge clk);
    while (gnt == 3'b000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_gnt"}, {29'd0, gnt}, {29'd0, expGnt});
    checkOutput({tag, "_noOverlap"}, {31'd0, res_valid}, 32'd0);
  endtask

  // Latency counts edges from the grant edge to the edge closing the res_valid cycle.
  task automatic runOp(input string tag, input logic [2:0] mask, input int lane,
                       input logic [11:0] expr, input logic [7:0] ans, input logic err, input int lat);
    int n = 0;
    applyStimulus(mask, expr);
    waitGrant(tag, 3'b001 << lane);
    req = 3'b000;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 12);
    checkOutput({tag, "_lat"}, n + 1, lat);
    checkOutput({tag, "_lane"}, {30'd0, res_lane}, lane);
    checkOutput({tag, "_ans"}, {24'd0, res_ans}, {24'd0, ans});
    checkOutput({tag, "_err"}, {31'd0, res_err}, {31'd0, err});
    checkOutput({tag, "_busyDone"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput({tag, "_validPulse"}, {31'd0, res_valid}, 32'd0);
  endtask

  task automatic expectQuiet(input string tag, input int cycles);
    logic sawValid = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (res_valid) sawValid = 1'b1;
    end
    checkOutput(tag, {31'd0, sawValid}, 32'd0);
  endtask

  initial begin
    logic [2:0] rrOrder [5];
    rrOrder = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    rst = 1'b1; req = 3'b000; flush = 1'b0; exp_bus = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", {29'd0, gnt}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_lane", {30'd0, res_lane}, 32'd0);
    checkOutput("rst_ans", {24'd0, res_ans}, 32'd0);
    checkOutput("rst_err", {31'd0, res_err}, 32'd0);
    rst = 1'b0;

    // All lanes held: pointer starts at 2, so lane 0 goes first.
    applyStimulus(3'b111, 12'h3A4);
    for (int i = 0; i < 5; i++) waitGrant($sformatf("rr%0d", i), rrOrder[i]);
    req = 3'b000;
    repeat (4) @(negedge clk);
    checkOutput("rr_idle", {31'd0, busy}, 32'd0);

    runOp("add", 3'b001, 0, 12'h3A4, 8'h07, 1'b0, 2);
    runOp("sub", 3'b010, 1, 12'h2B5, 8'hFD, 1'b0, 2);
    runOp("mul", 3'b100, 2, 12'hFCF, 8'hE1, 1'b0, 2);
    runOp("badOp", 3'b001, 0, 12'h7E3, 8'hFF, 1'b1, 2);
    runOp("zeroExp", 3'b010, 1, 12'h000, 8'hFF, 1'b1, 2);
`ifdef EVAL_DIV_EN
    runOp("div", 3'b100, 2, 12'h9D2, 8'h04, 1'b0, 5);
    runOp("divZero", 3'b100, 2, 12'h5D0, 8'hFF, 1'b1, 2);
`else
    runOp("divOff", 3'b100, 2, 12'h9D2, 8'hFF, 1'b1, 2);
`endif

    // Pointer is 2; a flushed IDLE cycle must neither grant nor move it, so lane 0 wins next.
    @(negedge clk);
    exp_bus = {3{12'h3A4}};
    req = 3'b111;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flushIdle_gnt", {29'd0, gnt}, 32'd0);
    checkOutput("flushIdle_busy", {31'd0, busy}, 32'd0);
    flush = 1'b0;
    req = 3'b000;
    runOp("afterFlush", 3'b011, 0, 12'h3A4, 8'h07, 1'b0, 2);

`ifdef EVAL_DIV_EN
    applyStimulus(3'b001, 12'h9D2);
    waitGrant("flushExec", 3'b001);
    req = 3'b000;
    @(negedge clk);
`else
    applyStimulus(3'b001, 12'h3A4);
    waitGrant("flushExec", 3'b001);
    req = 3'b000;
`endif
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flushExec_busy", {31'd0, busy}, 32'd0);
    checkOutput("flushExec_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("flushExec_gnt", {29'd0, gnt}, 32'd0);
    flush = 1'b0;
    expectQuiet("flushExec_noResult", 6);
    runOp("postFlush", 3'b010, 1, 12'h3A4, 8'h07, 1'b0, 2);

    // Reset in EXEC clears outputs without waiting for a clock and leaves nothing pending.
    applyStimulus(3'b001, 12'h2B5);
    waitGrant("rstExec", 3'b001);
    req = 3'b000;
    rst = 1'b1;
    #1;
    checkOutput("rstExec_gnt", {29'd0, gnt}, 32'd0);
    checkOutput("rstExec_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstExec_lane", {30'd0, res_lane}, 32'd0);
    checkOutput("rstExec_ans", {24'd0, res_ans}, 32'd0);
    checkOutput("rstExec_err", {31'd0, res_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expectQuiet("rstExec_noResult", 6);
    checkOutput("rstExec_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule
